// File: rtl/doorlock_pkg.sv
// doorlock_pkg: shared lock-state encodings, key codes and entry FSM states
package doorlock_pkg;
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ENTRY  = 2'b01;
  localparam logic [1:0] ST_VERIFY = 2'b10;
  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_CLEAR = 4'hF;
  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_VERIFY, S_LOCKOUT} fsm_t;
endpackage

// File: rtl/dl_timer.sv
// dl_timer: loadable down-counter that saturates at zero; done marks the final counted cycle
module dl_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign done = cnt <= W'(1);
endmodule

// File: rtl/ps_entry_ctrl.sv
// ps_entry_ctrl: keypad entry FSM feeding doorlock, with fail counting and timed lockout
module ps_entry_ctrl
  import doorlock_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000,
  parameter int VERIFY_CYC  = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYC    = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       door_open,
  output logic [1:0] state,
  output logic [3:0] ps_num,
  output logic       locked,
  output logic [1:0] fail_cnt
);
  localparam int CW = $clog2((TIMEOUT_CYC > LOCK_CYC ? TIMEOUT_CYC : LOCK_CYC) + 1);
  fsm_t cur, nxt;
  logic pass, pass_n, ld, done, data_key;
  logic [CW-1:0] ld_val;
  logic [3:0] ps_n;
  logic [1:0] fail_n;
  assign data_key = key_valid && key_code < KEY_ENTER;
  dl_timer #(.W(CW)) u_timer (
    .clk(clk), .rst(rst), .load(ld), .load_val(ld_val), .en(cur != S_IDLE), .done(done)
  );
  always_comb begin
    nxt = cur;
    ps_n = ps_num;
    fail_n = fail_cnt;
    pass_n = pass;
    ld = 1'b0;
    ld_val = '0;
    case (cur)
      S_IDLE: if (data_key) begin
        nxt = S_ENTRY;
        ps_n = key_code;
        ld = 1'b1;
        ld_val = CW'(TIMEOUT_CYC);
      end
      S_ENTRY: if (data_key) begin
        ps_n = key_code;
        ld = 1'b1;
        ld_val = CW'(TIMEOUT_CYC);
      end else if (key_valid && key_code == KEY_ENTER) begin
        nxt = S_VERIFY;
        ld = 1'b1;
        ld_val = CW'(VERIFY_CYC);
        pass_n = 1'b0;
      end else if (key_valid || done) begin
        nxt = S_IDLE;
        ps_n = '0;
      end
      S_VERIFY: begin
        // door_open on the last verify cycle still counts toward the verdict
        pass_n = pass | door_open;
        if (done) begin
          ps_n = '0;
          nxt = S_IDLE;
          fail_n = pass_n ? 2'd0 : fail_cnt + 2'd1;
          if (!pass_n && int'(fail_cnt) + 1 >= MAX_FAIL) begin
            nxt = S_LOCKOUT;
            ld = 1'b1;
            ld_val = CW'(LOCK_CYC);
            fail_n = 2'(MAX_FAIL);
          end
        end
      end
      S_LOCKOUT: if (done) begin
        nxt = S_IDLE;
        fail_n = '0;
      end
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= S_IDLE;
      pass <= 1'b0;
      state <= ST_IDLE;
      ps_num <= '0;
      locked <= 1'b0;
      fail_cnt <= '0;
    end else begin
      cur <= nxt;
      pass <= pass_n;
      state <= nxt == S_ENTRY ? ST_ENTRY : nxt == S_VERIFY ? ST_VERIFY : ST_IDLE;
      ps_num <= ps_n;
      locked <= nxt == S_LOCKOUT;
      fail_cnt <= fail_n;
    end
  end
endmodule

// File: tb/tb_ps_entry_ctrl.sv
// tb_ps_entry_ctrl: directed vector table, mid-verify reset sequence and randomized run vs a reference model
module tb_ps_entry_ctrl;
  localparam int TO = 8, VC = 2, MF = 3, LC = 10;
  logic clk = 0, rst = 1, key_valid = 0, door_open = 0;
  logic [3:0] key_code = 0, ps_num;
  logic [1:0] state, fail_cnt;
  logic locked;
  int checks = 0, errors = 0;
  int m_phase, m_left, m_ps, m_fail;
  bit m_pass;

  typedef struct {
    bit kv;
    logic [3:0] kc;
    logic [1:0] st;
    logic [3:0] ps;
    bit lk;
    logic [1:0] fc;
  } vec_t;
  vec_t tv[$];

  always #5 clk = ~clk;

  ps_entry_ctrl #(.TIMEOUT_CYC(TO), .VERIFY_CYC(VC), .MAX_FAIL(MF), .LOCK_CYC(LC)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .door_open(door_open),
    .state(state), .ps_num(ps_num), .locked(locked), .fail_cnt(fail_cnt)
  );

  task automatic chk(string n, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_ps = 0; m_fail = 0; m_pass = 0;
  endtask

  // phase: 0 idle, 1 entry, 2 verify, 3 lockout; m_left = cycles remaining in the phase
  task automatic model_step(bit kv, logic [3:0] kc, bit door);
    bit dk = kv && kc < 4'hE;
    case (m_phase)
      0: if (dk) begin m_phase = 1; m_left = TO; m_ps = kc; end
      1: begin
        if (dk) begin m_ps = kc; m_left = TO; end
        else if (kv && kc == 4'hE) begin m_phase = 2; m_left = VC; m_pass = 0; end
        else if (kv) begin m_phase = 0; m_ps = 0; end
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = 0; m_ps = 0; end
        end
      end
      2: begin
        m_pass = m_pass | door;
        m_left--;
        if (m_left == 0) begin
          m_ps = 0;
          m_phase = 0;
          if (m_pass) m_fail = 0;
          else if (m_fail + 1 < MF) m_fail++;
          else begin m_phase = 3; m_left = LC; m_fail = MF; end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin m_phase = 0; m_fail = 0; end
      end
    endcase
  endtask

  task automatic check_model();
    chk("state", 8'(state), 8'(m_phase == 1 ? 1 : m_phase == 2 ? 2 : 0));
    chk("ps_num", 8'(ps_num), 8'(m_ps));
    chk("locked", 8'(locked), 8'(m_phase == 3));
    chk("fail_cnt", 8'(fail_cnt), 8'(m_fail));
  endtask

  task automatic cycle(bit kv, logic [3:0] kc, bit auto_d, bit dv);
    key_valid = kv;
    key_code = kc;
    door_open = auto_d ? (state == 2'b10 && ps_num == 4'hD) : dv;
    @(posedge clk);
    model_step(kv, kc, door_open);
    #1;
    check_model();
    key_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    key_valid = 0;
    door_open = 0;
    @(posedge clk);
    #1;
    model_reset();
    check_model();
    rst = 0;
  endtask

  task automatic add(bit kv, logic [3:0] kc, logic [1:0] st, logic [3:0] ps, bit lk, logic [1:0] fc);
    tv.push_back('{kv, kc, st, ps, lk, fc});
  endtask

  initial begin
    add(1, 4'h3, 1, 4'h3, 0, 0);
    add(1, 4'hD, 1, 4'hD, 0, 0);
    add(1, 4'hE, 2, 4'hD, 0, 0);
    add(0, 4'h0, 2, 4'hD, 0, 0);
    add(0, 4'h0, 0, 4'h0, 0, 0);
    add(1, 4'hE, 0, 4'h0, 0, 0);
    add(1, 4'hF, 0, 4'h0, 0, 0);
    add(1, 4'h7, 1, 4'h7, 0, 0);
    add(1, 4'hF, 0, 4'h0, 0, 0);
    for (int f = 0; f < 3; f++) begin
      add(1, 4'h1, 1, 4'h1, 0, 2'(f));
      add(1, 4'hE, 2, 4'h1, 0, 2'(f));
      add(0, 4'h0, 2, 4'h1, 0, 2'(f));
      if (f < 2) add(0, 4'h0, 0, 4'h0, 0, 2'(f + 1));
    end
    add(0, 4'h0, 0, 4'h0, 1, 3);
    add(1, 4'hD, 0, 4'h0, 1, 3);
    add(1, 4'hE, 0, 4'h0, 1, 3);
    for (int i = 0; i < 7; i++) add(0, 4'h0, 0, 4'h0, 1, 3);
    add(0, 4'h0, 0, 4'h0, 0, 0);
    add(1, 4'h5, 1, 4'h5, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 4'h0, 1, 4'h5, 0, 0);
    add(0, 4'h0, 0, 4'h0, 0, 0);
    add(1, 4'h5, 1, 4'h5, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 4'h0, 1, 4'h5, 0, 0);
    add(1, 4'h9, 1, 4'h9, 0, 0);
    add(0, 4'h0, 1, 4'h9, 0, 0);

    do_reset();
    chk("rst_state", 8'(state), 8'h0);
    chk("rst_ps_num", 8'(ps_num), 8'h0);
    chk("rst_locked", 8'(locked), 8'h0);
    chk("rst_fail_cnt", 8'(fail_cnt), 8'h0);

    foreach (tv[i]) begin
      cycle(tv[i].kv, tv[i].kc, 1, 0);
      chk($sformatf("vec%0d_state", i), 8'(state), 8'(tv[i].st));
      chk($sformatf("vec%0d_ps_num", i), 8'(ps_num), 8'(tv[i].ps));
      chk($sformatf("vec%0d_locked", i), 8'(locked), 8'(tv[i].lk));
      chk($sformatf("vec%0d_fail_cnt", i), 8'(fail_cnt), 8'(tv[i].fc));
    end

    cycle(1, 4'hF, 1, 0);
    for (int f = 0; f < 2; f++) begin
      cycle(1, 4'h2, 1, 0);
      cycle(1, 4'hE, 1, 0);
      cycle(0, 4'h0, 1, 0);
      cycle(0, 4'h0, 1, 0);
    end
    chk("two_fails", 8'(fail_cnt), 8'h2);
    cycle(1, 4'h2, 1, 0);
    cycle(1, 4'hE, 1, 0);
    chk("in_verify", 8'(state), 8'h2);
    do_reset();
    chk("midv_state", 8'(state), 8'h0);
    chk("midv_ps_num", 8'(ps_num), 8'h0);
    chk("midv_locked", 8'(locked), 8'h0);
    chk("midv_fail_cnt", 8'(fail_cnt), 8'h0);
    cycle(0, 4'h0, 1, 0);
    chk("midv_after", 8'(state), 8'h0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 300 == 0) do_reset();
      else begin
        bit kv = ($urandom % 4) == 0;
        logic [3:0] kc = ($urandom % 4 == 0) ? (($urandom % 2) ? 4'hE : 4'hF) : 4'($urandom % 14);
        cycle(kv, kc, 0, 1'($urandom % 2));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
